// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared 640x480@60 timing constants, counter type and the
//                half-open range decode used by the sync generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int COUNT_W     = 10;
    localparam int COUNT_LIMIT = 1 << COUNT_W;

    typedef logic [COUNT_W-1:0] count_t;

    localparam int DEF_H_BACK  = 48;
    localparam int DEF_H_VIS   = 640;
    localparam int DEF_H_FRONT = 16;
    localparam int DEF_H_SYNC  = 96;
    localparam int DEF_V_BACK  = 33;
    localparam int DEF_V_VIS   = 480;
    localparam int DEF_V_FRONT = 10;
    localparam int DEF_V_SYNC  = 2;

    localparam int H_TOTAL      = DEF_H_BACK + DEF_H_VIS + DEF_H_FRONT + DEF_H_SYNC;
    localparam int H_VIS_START  = DEF_H_BACK;
    localparam int H_VIS_END    = H_VIS_START + DEF_H_VIS;
    localparam int H_SYNC_START = H_VIS_END + DEF_H_FRONT;

    localparam int V_TOTAL      = DEF_V_BACK + DEF_V_VIS + DEF_V_FRONT + DEF_V_SYNC;
    localparam int V_VIS_START  = DEF_V_BACK;
    localparam int V_VIS_END    = V_VIS_START + DEF_V_VIS;
    localparam int V_SYNC_START = V_VIS_END + DEF_V_FRONT;

    // Bounds are int so an end value of exactly 1024 is still representable.
    function automatic logic in_range(input count_t value, input int lo, input int hi);
        return (int'(value) >= lo) && (int'(value) < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_tick_div.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_tick_div
//  Description : Divides the system clock into pixel steps (combinational)
//                and a registered one-cycle pixel tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic reloj,
    input  logic resetM,
    output logic pix_step,
    output logic pix_tick
);

    localparam int                 c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    generate
        if (CLK_DIV < 1) begin : g_clk_div_check
            $error("pixel_tick_div: CLK_DIV must be at least 1");
        end
    endgenerate

    logic [c_DIV_W-1:0] r_div;
    logic               r_pix_tick;

    assign pix_step = (r_div == c_DIV_LAST);
    assign pix_tick = r_pix_tick;

    always_ff @(posedge reloj) begin
        if (resetM) begin
            r_div      <= '0;
            r_pix_tick <= 1'b0;
        end else begin
            r_div      <= pix_step ? '0 : r_div + 1'b1;
            r_pix_tick <= pix_step;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_gen
//  Description : VGA pixel/line counters with registered visible-area flags
//                and active-low syncs, decoded from next-state counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int H_BACK  = H_VIS_START,
    parameter int H_VIS   = H_VIS_END - H_VIS_START,
    parameter int H_FRONT = H_SYNC_START - H_VIS_END,
    parameter int H_SYNC  = H_TOTAL - H_SYNC_START,
    parameter int V_BACK  = V_VIS_START,
    parameter int V_VIS   = V_VIS_END - V_VIS_START,
    parameter int V_FRONT = V_SYNC_START - V_VIS_END,
    parameter int V_SYNC  = V_TOTAL - V_SYNC_START
) (
    input  logic               reloj,
    input  logic               resetM,
    output logic [COUNT_W-1:0] Qh,
    output logic [COUNT_W-1:0] Qv,
    output logic               H_ON,
    output logic               V_ON,
    output logic               hsync,
    output logic               vsync,
    output logic               pix_tick,
    output logic               frame_start
);

    localparam int     c_H_TOTAL      = H_BACK + H_VIS + H_FRONT + H_SYNC;
    localparam int     c_H_VIS_START  = H_BACK;
    localparam int     c_H_VIS_END    = H_BACK + H_VIS;
    localparam int     c_H_SYNC_START = c_H_VIS_END + H_FRONT;
    localparam count_t c_H_LAST       = count_t'(c_H_TOTAL - 1);

    localparam int     c_V_TOTAL      = V_BACK + V_VIS + V_FRONT + V_SYNC;
    localparam int     c_V_VIS_START  = V_BACK;
    localparam int     c_V_VIS_END    = V_BACK + V_VIS;
    localparam int     c_V_SYNC_START = c_V_VIS_END + V_FRONT;
    localparam count_t c_V_LAST       = count_t'(c_V_TOTAL - 1);

    generate
        if (c_H_TOTAL > COUNT_LIMIT) begin : g_h_total_check
            $error("vga_sync_gen: horizontal total exceeds 1024");
        end
        if (c_V_TOTAL > COUNT_LIMIT) begin : g_v_total_check
            $error("vga_sync_gen: vertical total exceeds 1024");
        end
    endgenerate

    logic   w_pix_step;
    logic   w_pix_tick;
    logic   w_h_wrap;
    logic   w_v_wrap;
    count_t w_qh_nxt;
    count_t w_qv_nxt;

    count_t r_qh;
    count_t r_qv;
    logic   r_h_on;
    logic   r_v_on;
    logic   r_hsync;
    logic   r_vsync;
    logic   r_frame_start;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_div (
        .reloj    (reloj),
        .resetM   (resetM),
        .pix_step (w_pix_step),
        .pix_tick (w_pix_tick)
    );

    always_comb begin
        w_h_wrap = (r_qh == c_H_LAST);
        w_v_wrap = (r_qv == c_V_LAST);
        w_qh_nxt = r_qh;
        w_qv_nxt = r_qv;
        if (w_pix_step) begin
            w_qh_nxt = w_h_wrap ? '0 : r_qh + 1'b1;
            if (w_h_wrap) begin
                w_qv_nxt = w_v_wrap ? '0 : r_qv + 1'b1;
            end
        end
    end

    // Flags are decoded from the next-state counters so they land on the
    // same edge as the counter values they describe.
    always_ff @(posedge reloj) begin
        if (resetM) begin
            r_qh          <= '0;
            r_qv          <= '0;
            r_h_on        <= 1'b0;
            r_v_on        <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_qh          <= w_qh_nxt;
            r_qv          <= w_qv_nxt;
            r_h_on        <= in_range(w_qh_nxt, c_H_VIS_START, c_H_VIS_END);
            r_v_on        <= in_range(w_qv_nxt, c_V_VIS_START, c_V_VIS_END);
            r_hsync       <= !in_range(w_qh_nxt, c_H_SYNC_START, c_H_TOTAL);
            r_vsync       <= !in_range(w_qv_nxt, c_V_SYNC_START, c_V_TOTAL);
            r_frame_start <= w_pix_step && w_h_wrap && w_v_wrap;
        end
    end

    assign Qh          = r_qh;
    assign Qv          = r_qv;
    assign H_ON        = r_h_on;
    assign V_ON        = r_v_on;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign pix_tick    = w_pix_tick;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sync_gen
//  Description : Scoreboard bench for vga_sync_gen: default timing, a reduced
//                geometry for frame-level behaviour, and CLK_DIV = 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

    // Instance 0: defaults, CLK_DIV=4.  Instance 1: 17x12 geometry, CLK_DIV=4.
    // Instance 2: defaults, CLK_DIV=1.
    logic       clk = 1'b0;
    logic       rst [3];
    logic [9:0] qh  [3];
    logic [9:0] qv  [3];
    logic       h_on[3];
    logic       v_on[3];
    logic       hs  [3];
    logic       vs  [3];
    logic       pt  [3];
    logic       fs  [3];

    vga_sync_gen u_dut_a (
        .reloj(clk), .resetM(rst[0]), .Qh(qh[0]), .Qv(qv[0]), .H_ON(h_on[0]), .V_ON(v_on[0]),
        .hsync(hs[0]), .vsync(vs[0]), .pix_tick(pt[0]), .frame_start(fs[0])
    );

    vga_sync_gen #(
        .CLK_DIV(4), .H_BACK(4), .H_VIS(8), .H_FRONT(2), .H_SYNC(3),
        .V_BACK(3), .V_VIS(5), .V_FRONT(2), .V_SYNC(2)
    ) u_dut_b (
        .reloj(clk), .resetM(rst[1]), .Qh(qh[1]), .Qv(qv[1]), .H_ON(h_on[1]), .V_ON(v_on[1]),
        .hsync(hs[1]), .vsync(vs[1]), .pix_tick(pt[1]), .frame_start(fs[1])
    );

    vga_sync_gen #(
        .CLK_DIV(1)
    ) u_dut_c (
        .reloj(clk), .resetM(rst[2]), .Qh(qh[2]), .Qv(qv[2]), .H_ON(h_on[2]), .V_ON(v_on[2]),
        .hsync(hs[2]), .vsync(vs[2]), .pix_tick(pt[2]), .frame_start(fs[2])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef struct {
        int c;
        int d;
        int s;
        int v;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // Measurements taken by the monitor (instance 1 frame, instance 0 ticks).
    int b_last_fs   = -1;
    int b_period    = -1;
    int b_hs_cnt    = 0;
    int b_pulses    = -1;
    int a_ticks     = 0;
    int a_double    = 0;
    logic b_prev_hs = 1'b1;
    logic a_prev_pt = 1'b0;

    function automatic string sig_name(int s);
        case (s)
            0:       return "Qh";
            1:       return "Qv";
            2:       return "H_ON";
            3:       return "V_ON";
            4:       return "hsync";
            5:       return "vsync";
            6:       return "pix_tick";
            7:       return "frame_start";
            8:       return "frame_period";
            9:       return "hsync_pulses";
            10:      return "tick_count";
            default: return "tick_double";
        endcase
    endfunction

    function automatic int get_sig(int d, int s);
        case (s)
            0:       return int'(qh[d]);
            1:       return int'(qv[d]);
            2:       return int'(h_on[d]);
            3:       return int'(v_on[d]);
            4:       return int'(hs[d]);
            5:       return int'(vs[d]);
            6:       return int'(pt[d]);
            7:       return int'(fs[d]);
            8:       return b_period;
            9:       return b_pulses;
            10:      return a_ticks;
            default: return a_double;
        endcase
    endfunction

    task automatic push(input int c, input int d, input int s, input int v);
        exp_t e;
        e.c = c; e.d = d; e.s = s; e.v = v;
        sb.push_back(e);
    endtask

    task automatic push_all(input int c, input int d, input int eqh, input int eqv,
                            input int ehon, input int evon, input int ehs, input int evs,
                            input int ept, input int efs);
        push(c, d, 0, eqh); push(c, d, 1, eqv); push(c, d, 2, ehon); push(c, d, 3, evon);
        push(c, d, 4, ehs); push(c, d, 5, evs); push(c, d, 6, ept);  push(c, d, 7, efs);
    endtask

    task automatic wait_cyc(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    // Monitor: update measurements, then retire every expectation due now.
    initial forever begin
        @(negedge clk);
        if (cyc >= 4) begin
            if (pt[0]) a_ticks++;
            if (pt[0] && a_prev_pt) a_double++;
            a_prev_pt = pt[0];
        end
        if (b_prev_hs && !hs[1]) b_hs_cnt++;
        b_prev_hs = hs[1];
        if (fs[1]) begin
            if (b_last_fs >= 0) begin
                b_period = cyc - b_last_fs;
                b_pulses = b_hs_cnt;
            end
            b_last_fs = cyc;
            b_hs_cnt  = 0;
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].c <= cyc) begin
                int act;
                act = get_sig(sb[i].d, sb[i].s);
                n_total++;
                if (sb[i].c < cyc) begin
                    n_bad++;
                    $display("FAIL %s dut%0d: check for cyc %0d missed (now %0d)",
                             sig_name(sb[i].s), sb[i].d, sb[i].c, cyc);
                end else if (act != sb[i].v) begin
                    n_bad++;
                    $display("FAIL %s dut%0d cyc=%0d: got %0d, want %0d",
                             sig_name(sb[i].s), sb[i].d, cyc, act, sb[i].v);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        for (int d = 0; d < 3; d++) rst[d] = 1'b1;
        for (int d = 0; d < 3; d++) begin
            push_all(1, d, 0, 0, 0, 0, 1, 1, 0, 0);
            push_all(3, d, 0, 0, 0, 0, 1, 1, 0, 0);
        end

        // Release after 3 reset edges; edge cyc 4 is the first running edge.
        wait_cyc(3);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;

        // Default timing, CLK_DIV=4: pixel n appears after cyc n*4+3.
        push_all(4, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        push(6, 0, 0, 0);    push(6, 0, 6, 0);
        push(7, 0, 0, 1);    push(7, 0, 6, 1);
        push(8, 0, 0, 1);    push(8, 0, 6, 0);
        push(11, 0, 0, 2);   push(11, 0, 6, 1);
        push(403, 0, 10, 100);
        push(191, 0, 0, 47); push(191, 0, 2, 0);
        push(195, 0, 0, 48); push(195, 0, 2, 1);
        push(2751, 0, 0, 687); push(2751, 0, 2, 1);
        push(2755, 0, 0, 688); push(2755, 0, 2, 0);
        push(2815, 0, 0, 703); push(2815, 0, 4, 1);
        push(2819, 0, 0, 704); push(2819, 0, 4, 0);
        push_all(3199, 0, 799, 0, 0, 0, 0, 1, 1, 0);
        push_all(3203, 0, 0, 1, 0, 0, 1, 1, 1, 0);
        push(3205, 0, 11, 0);

        // Reduced geometry 17x12: vertical decode, frame wrap and period.
        push_all(479, 1, 0, 7, 0, 1, 1, 1, 1, 0);
        push_all(543, 1, 16, 7, 0, 1, 0, 1, 1, 0);
        push_all(547, 1, 0, 8, 0, 0, 1, 1, 1, 0);
        push(679, 1, 1, 9);  push(679, 1, 5, 1);
        push(683, 1, 1, 10); push(683, 1, 5, 0);
        push_all(815, 1, 16, 11, 0, 0, 0, 0, 1, 0);
        push_all(819, 1, 0, 0, 0, 0, 1, 1, 1, 1);
        push(820, 1, 7, 0);  push(820, 1, 6, 0);
        push(1635, 1, 7, 1); push(1635, 1, 8, 816); push(1635, 1, 9, 12);
        push_all(2015, 1, 10, 5, 1, 1, 1, 1, 1, 0);

        // CLK_DIV=1: a step on every edge, one line per 800 cycles.
        push_all(4, 2, 1, 0, 0, 0, 1, 1, 1, 0);
        push(5, 2, 0, 2);    push(5, 2, 6, 1);
        push(51, 2, 0, 48);  push(51, 2, 2, 1);
        push(707, 2, 0, 704); push(707, 2, 4, 0);
        push(802, 2, 0, 799); push(802, 2, 1, 0);
        push_all(803, 2, 0, 1, 0, 0, 1, 1, 1, 0);
        push(1603, 2, 0, 0); push(1603, 2, 1, 2); push(1603, 2, 6, 1);

        // One-cycle reset in the middle of frame 2 of the reduced geometry.
        wait_cyc(2016);
        rst[1] = 1'b1;
        push_all(2017, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        wait_cyc(2017);
        rst[1] = 1'b0;
        push(2020, 1, 0, 0);
        push(2021, 1, 0, 1);  push(2021, 1, 6, 1);
        push(2033, 1, 0, 4);  push(2033, 1, 2, 1);
        push(2221, 1, 1, 3);  push(2221, 1, 3, 1);

        wait_cyc(3210);
        n_total++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
